// File: rtl/dram_arbiter.sv
// dram_arbiter: shares one DRAM port between instruction fetch (read),
// data load (read) and data store (write). One transaction in flight at a
// time, data-first priority, with a starvation counter that forces a fetch
// grant after STARVE_LIMIT consecutive data grants while fetch is waiting.
module dram_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  // instruction fetch client
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_fin,
  output logic [DATA_W-1:0] if_data,
  // data load client
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_fin,
  output logic [DATA_W-1:0] ld_data,
  // data store client
  input  logic              st_req,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  output logic              st_fin,
  // DRAM controller side
  output logic              dram_rd_req,
  output logic [ADDR_W-1:0] dram_rd_addr,
  input  logic [DATA_W-1:0] dram_rd_data,
  input  logic              dram_rd_fin,
  output logic              dram_wr_req,
  output logic [ADDR_W-1:0] dram_wr_addr,
  output logic [DATA_W-1:0] dram_wr_data,
  input  logic              dram_wr_fin,
  // status
  output logic              busy,
  output logic [1:0]        owner
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_e;
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LD   = 2'd2,
    OWN_ST   = 2'd3
  } owner_e;

  // Counter must hold 0..STARVE_LIMIT; keep at least one bit for LIMIT=0.
  localparam int               CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  state_e           state_q;
  owner_e           owner_q;
  owner_e           grant_d;
  logic [CNT_W-1:0] starve_q;
  logic [CNT_W-1:0] starve_d;

  // IDLE-cycle arbitration: starved fetch first, then store, load, fetch.
  always_comb begin
    // NOTE: every combinational output gets a default first, otherwise an
    // unassigned path holds its old value and synthesis infers a latch.
    grant_d = OWN_NONE;
    if (if_req && (starve_q == LIMIT)) grant_d = OWN_IF;
    else if (st_req)                   grant_d = OWN_ST;
    else if (ld_req)                   grant_d = OWN_LD;
    else if (if_req)                   grant_d = OWN_IF;
  end

  // Starvation count: cleared by a fetch grant, bumped by a data grant
  // while fetch is waiting; a waiting fetch at LIMIT always wins, so the
  // increment can never overshoot.
  always_comb begin
    starve_d = starve_q;
    if (grant_d == OWN_IF) begin
      starve_d = '0;
    end else if ((grant_d != OWN_NONE) && if_req && (starve_q != LIMIT)) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  // Transaction FSM with registered client and DRAM outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the data/address registers are reset too (not just control),
      // because every output must read 0 while reset is asserted.
      state_q      <= IDLE;
      owner_q      <= OWN_NONE;
      starve_q     <= '0;
      if_fin       <= 1'b0;
      if_data      <= '0;
      ld_fin       <= 1'b0;
      ld_data      <= '0;
      st_fin       <= 1'b0;
      dram_rd_req  <= 1'b0;
      dram_rd_addr <= '0;
      dram_wr_req  <= 1'b0;
      dram_wr_addr <= '0;
      dram_wr_data <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values; the fin defaults below make them one-cycle pulses.
      if_fin <= 1'b0;
      ld_fin <= 1'b0;
      st_fin <= 1'b0;
      unique case (state_q)
        IDLE: begin
          starve_q <= starve_d;
          owner_q  <= grant_d;
          unique case (grant_d)
            OWN_IF: begin
              dram_rd_req  <= 1'b1;
              dram_rd_addr <= if_addr;
              state_q      <= RD;
            end
            OWN_LD: begin
              dram_rd_req  <= 1'b1;
              dram_rd_addr <= ld_addr;
              state_q      <= RD;
            end
            OWN_ST: begin
              dram_wr_req  <= 1'b1;
              dram_wr_addr <= st_addr;
              dram_wr_data <= st_data;
              state_q      <= WR;
            end
            default: ;
          endcase
        end
        RD: begin
          if (dram_rd_fin) begin
            dram_rd_req <= 1'b0;
            if (owner_q == OWN_IF) begin
              if_data <= dram_rd_data;
              if_fin  <= 1'b1;
            end else begin
              ld_data <= dram_rd_data;
              ld_fin  <= 1'b1;
            end
            state_q <= DONE;
          end
        end
        WR: begin
          if (dram_wr_fin) begin
            dram_wr_req <= 1'b0;
            st_fin      <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          owner_q <= OWN_NONE;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy  = (state_q != IDLE);
  assign owner = owner_q;

endmodule
